huffman_canonical_decoder: RTL and testbench

Parametrised, table-programmable successor to the fixed 18-symbol serial Huffman decoder. Consumes a bit-serial code stream under a valid/ready handshake and decodes it with the canonical-Huffman first-code/count algorithm, one bit per cycle. Emits symbols on a backpressurable output port. Code-length counts and the symbol table are runtime-programmable; reset defaults reproduce the legacy 18-symbol code exactly.

---
 rtl/huffman_canonical_decoder_pkg.sv | 31 +++
 rtl/huffman_code_table.sv | 64 ++++++
 rtl/huffman_canonical_decoder.sv | 152 +++++++++++++++
 tb/tb_huffman_canonical_decoder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/huffman_canonical_decoder_pkg.sv
// Shared definitions for the canonical Huffman decoder: config selector type
// and reset-default contents that reproduce the legacy 18-symbol code.
package huffman_pkg;

    typedef enum logic {
        CFG_COUNT  = 1'b0,
        CFG_SYMBOL = 1'b1
    } cfg_sel_e;

    localparam int DEF_NUM_LENS = 8;

    // Codes per length, index 0 = length 1.
    localparam int DEF_COUNTS [DEF_NUM_LENS] = '{
        32'sd0, 32'sd3, 32'sd1, 32'sd0, 32'sd0, 32'sd3, 32'sd9, 32'sd2
    };

    function automatic int default_count(input int len_idx);
        int result;
        if ((len_idx >= 32'sd0) && (len_idx < DEF_NUM_LENS)) begin
            result = DEF_COUNTS[len_idx];
        end else begin
            result = 32'sd0;
        end
        return result;
    endfunction

    function automatic int default_symbol(input int idx);
        return idx + 32'sd1;
    endfunction

endpackage

// File: rtl/huffman_code_table.sv
// Programmable code-length count table and symbol table with legacy reset
// defaults and combinational read ports.
module huffman_code_table
    import huffman_pkg::*;
#(
    parameter int SYM_W    = 5,
    parameter int MAX_LEN  = 8,
    parameter int NUM_SYMS = 18,
    parameter int IDX_W    = 5,
    parameter int ADDR_W   = 5,
    parameter int CFG_W    = 5,
    parameter int LEN_W    = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_we,
    input  cfg_sel_e          i_sel,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [CFG_W-1:0]  i_data,
    input  logic [LEN_W-1:0]  i_cnt_idx,
    output logic [IDX_W-1:0]  o_cnt,
    input  logic [ADDR_W-1:0] i_sym_addr,
    output logic [SYM_W-1:0]  o_sym
);

    logic [IDX_W-1:0] r_cnt [MAX_LEN];
    logic [SYM_W-1:0] r_sym [NUM_SYMS];

    // Register files: defaults on reset, gated write port otherwise; out-of-range addresses match no entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_cnt[i] <= IDX_W'(default_count(i));
            end
            for (int i = 0; i < NUM_SYMS; i++) begin
                r_sym[i] <= SYM_W'(default_symbol(i));
            end
        end else if (i_we) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if ((i_sel == CFG_COUNT) && (int'(i_addr) == i)) begin
                    r_cnt[i] <= i_data[IDX_W-1:0];
                end
            end
            for (int i = 0; i < NUM_SYMS; i++) begin
                if ((i_sel == CFG_SYMBOL) && (int'(i_addr) == i)) begin
                    r_sym[i] <= i_data[SYM_W-1:0];
                end
            end
        end
    end

    // Combinational read muxes; unmatched indices read as zero.
    always_comb begin
        o_cnt = '0;
        o_sym = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            o_cnt = (int'(i_cnt_idx) == i) ? r_cnt[i] : o_cnt;
        end
        for (int i = 0; i < NUM_SYMS; i++) begin
            o_sym = (int'(i_sym_addr) == i) ? r_sym[i] : o_sym;
        end
    end

endmodule

// File: rtl/huffman_canonical_decoder.sv
// Bit-serial canonical Huffman decoder (first-code/count walk, one bit per
// cycle) with valid/ready input and backpressurable symbol output.
module huffman_canonical_decoder
    import huffman_pkg::*;
#(
    parameter  int SYM_W    = 5,
    parameter  int MAX_LEN  = 8,
    parameter  int NUM_SYMS = 18,
    localparam int IDX_W    = $clog2(NUM_SYMS + 1),
    localparam int ADDR_W   = (NUM_SYMS > 1) ? $clog2(NUM_SYMS) : 1,
    localparam int CFG_W    = (SYM_W > IDX_W) ? SYM_W : IDX_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic              in_bit,
    output logic              in_ready,
    output logic              sym_valid,
    output logic [SYM_W-1:0]  sym_data,
    input  logic              sym_ready,
    output logic              err,
    output logic              busy,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [CFG_W-1:0]  cfg_data
);

    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CW      = MAX_LEN + 1;
    localparam int AW_FULL = ((IDX_W > CW) ? IDX_W : CW) + 1;

    logic [LEN_W-1:0] r_len;
    logic [CW-1:0]    r_code;
    logic [CW-1:0]    r_first;
    logic [IDX_W-1:0] r_index;
    logic             r_sym_valid;
    logic [SYM_W-1:0] r_sym_data;
    logic             r_err;
    logic             r_busy;

    logic               w_accept;
    logic               w_cfg_en;
    logic [CW-1:0]      w_c;
    logic [CW-1:0]      w_diff;
    logic [IDX_W-1:0]   w_n;
    logic [AW_FULL-1:0] w_addr_full;
    logic               w_addr_bad;
    logic               w_match;
    logic               w_last;
    logic               w_to_root;
    logic               w_emit;
    logic               w_error;
    logic [SYM_W-1:0]   w_tab_sym;
    logic [LEN_W-1:0]   w_len_nxt;
    logic [CW-1:0]      w_code_nxt;
    logic [CW-1:0]      w_first_nxt;
    logic [IDX_W-1:0]   w_index_nxt;

    assign in_ready  = !r_sym_valid || sym_ready;
    assign sym_valid = r_sym_valid;
    assign sym_data  = r_sym_data;
    assign err       = r_err;
    assign busy      = r_busy;

    assign w_accept = in_valid && in_ready;
    assign w_cfg_en = cfg_we && !r_busy && !w_accept;

    // r_len is the length-minus-one index of the code being extended.
    huffman_code_table #(
        .SYM_W    (SYM_W),
        .MAX_LEN  (MAX_LEN),
        .NUM_SYMS (NUM_SYMS),
        .IDX_W    (IDX_W),
        .ADDR_W   (ADDR_W),
        .CFG_W    (CFG_W),
        .LEN_W    (LEN_W)
    ) u_table (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_we       (w_cfg_en),
        .i_sel      (cfg_sel_e'(cfg_sel)),
        .i_addr     (cfg_addr),
        .i_data     (cfg_data),
        .i_cnt_idx  (r_len),
        .o_cnt      (w_n),
        .i_sym_addr (w_addr_full[ADDR_W-1:0]),
        .o_sym      (w_tab_sym)
    );

    assign w_c         = CW'({r_code, in_bit});
    assign w_diff      = w_c - r_first;
    assign w_match     = (w_c >= r_first) && (AW_FULL'(w_diff) < AW_FULL'(w_n));
    assign w_addr_full = AW_FULL'(r_index) + AW_FULL'(w_diff);
    assign w_addr_bad  = (w_addr_full >= AW_FULL'(NUM_SYMS));
    assign w_last      = (r_len == LEN_W'(MAX_LEN - 1));
    assign w_to_root   = w_match || w_last;
    assign w_emit      = w_accept && w_match && !w_addr_bad;
    assign w_error     = w_accept && ((w_match && w_addr_bad) || (!w_match && w_last));

    // Next code-walk state: back to root on any terminal bit, else descend one level.
    always_comb begin
        w_len_nxt   = r_len;
        w_code_nxt  = r_code;
        w_first_nxt = r_first;
        w_index_nxt = r_index;
        if (w_accept && w_to_root) begin
            w_len_nxt   = '0;
            w_code_nxt  = '0;
            w_first_nxt = '0;
            w_index_nxt = '0;
        end else if (w_accept) begin
            w_len_nxt   = r_len + LEN_W'(1);
            w_code_nxt  = w_c;
            w_first_nxt = CW'((r_first + CW'(w_n)) << 1);
            w_index_nxt = r_index + w_n;
        end else begin
            w_len_nxt   = r_len;
            w_code_nxt  = r_code;
            w_first_nxt = r_first;
            w_index_nxt = r_index;
        end
    end

    // Walk state, output symbol register and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_len       <= '0;
            r_code      <= '0;
            r_first     <= '0;
            r_index     <= '0;
            r_sym_valid <= 1'b0;
            r_sym_data  <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_len   <= w_len_nxt;
            r_code  <= w_code_nxt;
            r_first <= w_first_nxt;
            r_index <= w_index_nxt;
            r_busy  <= (w_len_nxt != '0);
            r_err   <= w_error;
            if (w_emit) begin
                r_sym_valid <= 1'b1;
                r_sym_data  <= w_tab_sym;
            end else if (sym_ready) begin
                r_sym_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_huffman_canonical_decoder.sv
// Self-checking bench: code-table vectors with a symbol scoreboard plus
// directed sequences for backpressure, reprogramming, errors and reset.
module tb_huffman_canonical_decoder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_bit;
    logic       in_ready;
    logic       sym_valid;
    logic [4:0] sym_data;
    logic       sym_ready;
    logic       err;
    logic       busy;
    logic       cfg_we;
    logic       cfg_sel;
    logic [4:0] cfg_addr;
    logic [4:0] cfg_data;

    typedef struct {
        logic [7:0] bits;
        int         nbits;
        int         sym;
    } vec_t;

    vec_t vecs [18];
    int   q_exp [$];
    int   total = 0;
    int   bad = 0;
    int   err_seen = 0;
    int   err_exp = 0;
    int   mon_exp;
    int   t1 [4] = '{0, 2, 3, 17};

    huffman_canonical_decoder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .sym_valid (sym_valid),
        .sym_data  (sym_data),
        .sym_ready (sym_ready),
        .err       (err),
        .busy      (busy),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: a symbol transfers at the next posedge when valid && ready here.
    always @(negedge clk) begin
        if (reset_n && sym_valid && sym_ready) begin
            if (q_exp.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_sym: got %0d expected none", sym_data);
            end else begin
                mon_exp = q_exp.pop_front();
                check("sym", {27'd0, sym_data}, mon_exp);
            end
        end
        if (reset_n && err) err_seen++;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        int waited = 0;
        in_valid = 1'b1;
        in_bit   = b;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_code(input int vi, input bit gaps);
        for (int i = vecs[vi].nbits - 1; i >= 0; i--) begin
            if (gaps) idle($urandom_range(0, 2));
            if (i == 0) q_exp.push_back(vecs[vi].sym);
            send_bit(vecs[vi].bits[i]);
        end
    endtask

    task automatic cfg_write(input logic sel, input logic [4:0] addr, input logic [4:0] data);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_addr = addr;
        cfg_data = data;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q_exp.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", q_exp.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; sym_ready = 1'b1;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = 5'd0; cfg_data = 5'd0;

        vecs[0] = '{8'b00, 2, 1};
        vecs[1] = '{8'b01, 2, 2};
        vecs[2] = '{8'b10, 2, 3};
        vecs[3] = '{8'b110, 3, 4};
        for (int s = 5; s <= 7; s++)   vecs[s-1] = '{8'(56 + s - 5), 6, s};
        for (int s = 8; s <= 16; s++)  vecs[s-1] = '{8'(118 + s - 8), 7, s};
        for (int s = 17; s <= 18; s++) vecs[s-1] = '{8'(254 + s - 17), 8, s};

        repeat (3) @(posedge clk);
        #1;
        check("rst_sym_valid", {31'd0, sym_valid}, 32'd0);
        check("rst_sym_data", {27'd0, sym_data}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Basic decodes with one-cycle latency
        foreach (t1[k]) begin
            send_code(t1[k], 1'b0);
            @(negedge clk);
            check("latency_valid", {31'd0, sym_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        drain();

        // All 18 legacy codes with random gaps
        for (int v = 0; v < 18; v++) send_code(v, 1'b1);
        drain();
        check("stream_no_err", err_seen, 32'd0);

        // Backpressure after symbol 2
        send_bit(1'b0);
        sym_ready = 1'b0;
        q_exp.push_back(2);
        send_bit(1'b1);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_valid", {31'd0, sym_valid}, 32'd1);
            check("bp_data", {27'd0, sym_data}, 32'd2);
        end
        @(posedge clk);
        #1;
        sym_ready = 1'b1;
        send_bit(1'b1);
        q_exp.push_back(3);
        send_bit(1'b0);
        drain();

        // Config write while busy must be dropped
        send_bit(1'b1);
        check("busy_mid_code", {31'd0, busy}, 32'd1);
        cfg_write(1'b0, 5'd1, 5'd0);
        send_bit(1'b1);
        q_exp.push_back(4);
        send_bit(1'b0);
        drain();

        // Reprogram while idle
        cfg_write(1'b0, 5'd0, 5'd2);
        for (int a = 1; a < 8; a++) cfg_write(1'b0, 5'(a), 5'd0);
        cfg_write(1'b1, 5'd0, 5'd7);
        cfg_write(1'b1, 5'd1, 5'd9);
        q_exp.push_back(7);
        send_bit(1'b0);
        q_exp.push_back(9);
        send_bit(1'b1);
        drain();

        // Invalid code: only one length-1 code
        cfg_write(1'b0, 5'd0, 5'd1);
        repeat (7) send_bit(1'b1);
        check("err_busy", {31'd0, busy}, 32'd1);
        send_bit(1'b1);
        err_exp++;
        @(negedge clk);
        check("err_pulse", {31'd0, err}, 32'd1);
        check("err_no_sym", {31'd0, sym_valid}, 32'd0);
        @(negedge clk);
        check("err_one_cycle", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;
        q_exp.push_back(7);
        send_bit(1'b0);
        drain();
        check("err_count", err_seen, err_exp);

        // Reset mid-code restores defaults
        repeat (3) send_bit(1'b1);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", {31'd0, sym_valid}, 32'd0);
        check("mid_rst_data", {27'd0, sym_data}, 32'd0);
        check("mid_rst_err", {31'd0, err}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        send_bit(1'b0);
        q_exp.push_back(2);
        send_bit(1'b1);
        drain();
        check("final_err_count", err_seen, err_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
